// File: rtl/boot_loader_pkg.sv
// Shared types and widths for the byte-stream program loader.
package boot_loader_pkg;

  localparam int ADDR_W  = 16;
  localparam int WORD_W  = 32;
  localparam int HDR_LEN = 2;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CSUM   = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } bl_state_e;

  function automatic logic takes_bytes(bl_state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Collects four stream bytes MSB-first into one word; full_o pulses with the 4th byte.
module boot_word_packer
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (shift_en_i) begin
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[WORD_W-9:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign full_o = shift_en_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed word stream into memory while holding the core, then
// passes core writes through. Optional trailing XOR checksum: BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_WORDS = 16384
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [WORD_W-1:0] cpu_mem_wdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bl_state_e END_STATE = CSUM;
`else
  localparam bl_state_e END_STATE = RUN;
`endif

  bl_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       hdr_cnt;
  logic              rx_fire;
  logic              word_full;
  logic [WORD_W-1:0] word;
  logic              csum_ok;

  assign rx_ready = takes_bytes(state_q);
  assign rx_fire  = rx_valid && rx_ready;
  assign hdr_cnt  = {cnt_q[15:8], rx_data};

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (rx_fire && (state_q == DATA)),
    .clear_i    (state_q == HDR_HI),
    .byte_i     (rx_data),
    .word_o     (word),
    .full_o     (word_full)
  );

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Header bytes are excluded: the sum only covers DATA-state bytes.
  always_comb begin
    csum_d = csum_q;
    if (state_q == HDR_HI)
      csum_d = '0;
    else if (rx_fire && (state_q == DATA))
      csum_d = csum_q ^ rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum_ok = (rx_data == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      HDR_HI: if (rx_fire) begin
        cnt_d   = {rx_data, 8'h00};
        state_d = HDR_LO;
      end
      HDR_LO: if (rx_fire) begin
        cnt_d = hdr_cnt;
        if ({16'd0, hdr_cnt} > MAX_WORDS) state_d = ERROR;
        else if (hdr_cnt == 16'd0)        state_d = END_STATE;
        else                              state_d = DATA;
      end
      DATA: if (word_full) state_d = WRITE;
      WRITE: begin
        cnt_d   = cnt_q - 16'd1;
        addr_d  = addr_q + 16'd4;
        state_d = (cnt_q == 16'd1) ? END_STATE : DATA;
      end
      CSUM: if (rx_fire) state_d = csum_ok ? RUN : ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HDR_HI;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Output mux is decoded from the state register, so reset drops mem_write at once.
  always_comb begin
    if (state_q == RUN) begin
      mem_write = cpu_mem_write;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
    end else begin
      mem_write = (state_q == WRITE);
      mem_addr  = addr_q;
      mem_wdata = word;
    end
  end

  assign cpu_hold = (state_q != RUN);
  assign done     = (state_q == RUN);
  assign error    = (state_q == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: stream loads vs a word-list reference model.
module tb_boot_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cpu_mem_write;
  logic [15:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, done, error;

  boot_loader dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] wq[$];
  int          last_acc_cyc;

  // Loader writes seen by memory: sampled at the committing edge.
  always @(posedge clk) begin
    if (mem_write && cpu_hold) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic rand_cpu();
    cpu_mem_write = 1'($urandom_range(0, 1));
    cpu_mem_addr  = 16'($urandom);
    cpu_mem_wdata = $urandom;
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit gaps);
    int idx = 0;
    int budget = q.size() * 20 + 40;
    bit fire;
    while (idx < q.size() && budget > 0) begin
      @(negedge clk);
      rand_cpu();
      rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = q[idx];
      fire = rx_valid && rx_ready;
      @(posedge clk);
      if (fire) begin
        last_acc_cyc = cyc;
        idx++;
      end
      budget--;
    end
    if (idx != q.size()) chk("rx_timeout", 32'(idx), 32'(q.size()));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference: words land at consecutive addresses; outcome from count and checksum rule.
  task automatic do_load(input bit gaps, input bit bad_csum);
    logic [7:0] q[$];
    logic [7:0] xs = 8'h00;
    int n = wq.size();
    int done_cyc = -1;
    bit exp_err;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    foreach (wq[i]) begin
      for (int b = 3; b >= 0; b--) begin
        q.push_back(8'(wq[i] >> (8 * b)));
        xs ^= 8'(wq[i] >> (8 * b));
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    q.push_back(bad_csum ? (xs ^ 8'h01) : xs);
    exp_err = bad_csum;
`else
    exp_err = 1'b0;
`endif
    clear_log();
    send_stream(q, gaps);
    for (int t = 0; t < 40 && done_cyc < 0; t++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (done || error) done_cyc = cyc;
    end
    if (done_cyc < 0) chk("end_timeout", 0, 1);
    chk("done", done, !exp_err);
    chk("error", error, exp_err);
    chk("cpu_hold", cpu_hold, exp_err);
    chk("n_writes", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr[i], 16'(BASE + 4 * i));
      chk($sformatf("wr_data[%0d]", i), wr_data[i], wq[i]);
      if (i > 0) chk("wr_spacing_ge5", (wr_cyc[i] - wr_cyc[i-1]) >= 5, 1);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("end_latency", 32'(done_cyc - last_acc_cyc), 1);
`else
    if (n == 0) chk("end_latency", 32'(done_cyc - last_acc_cyc), 1);
    else if (wr_cyc.size() > 0) chk("end_latency", 32'(done_cyc - wr_cyc[wr_cyc.size()-1]), 1);
`endif
  endtask

  task automatic check_passthrough();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rand_cpu();
      #1;
      chk("pt_write", mem_write, cpu_mem_write);
      chk("pt_addr", mem_addr, cpu_mem_addr);
      chk("pt_wdata", mem_wdata, cpu_mem_wdata);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    cpu_mem_write = 1'b1;
    cpu_mem_addr = 16'h1234;
    cpu_mem_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // Directed two-word load, then core pass-through.
    wq = '{32'h2008_0005, 32'hAC08_0000};
    do_load(1'b0, 1'b0);
    check_passthrough();

    // Empty program.
    do_reset();
    wq.delete();
    do_load(1'b0, 1'b0);

    // Count above MAX_WORDS aborts; trailing bytes ignored.
    do_reset();
    clear_log();
    q = '{8'h40, 8'h01};
    if (32'h4001 > MAXW) begin
      send_stream(q, 1'b0);
      @(negedge clk);
      chk("ovf_error", error, 1);
      chk("ovf_rx_ready", rx_ready, 0);
      chk("ovf_hold", cpu_hold, 1);
      for (int i = 0; i < 8; i++) begin
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        rand_cpu();
        @(negedge clk);
        chk("ovf_stuck", {rx_ready, error, cpu_hold, done}, 4'b0110);
      end
      chk("ovf_no_writes", 32'(wr_addr.size()), 0);
    end

    // Random 3-word load with 50% valid gaps, then assorted random loads.
    for (int r = 0; r < 5; r++) begin
      int n = (r == 0) ? 3 : $urandom_range(1, 6);
      do_reset();
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      do_load(1'b1, 1'b0);
    end

    // Reset mid-word: partial word and position are discarded.
    do_reset();
    q = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stream(q, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_vals("midword");
    @(negedge clk);
    reset = 1'b1;

    // Reset during the WRITE cycle drops mem_write without waiting for a clock.
    clear_log();
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(q, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("midwr_write_hi", mem_write, 1);
    chk("midwr_addr", mem_addr, BASE);
    #2 reset = 1'b0;
    #1 chk("midwr_async_drop", mem_write, 0);
    @(negedge clk);
    reset = 1'b1;
    wq = '{32'hDEAD_BEEF};
    do_load(1'b0, 1'b0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reset();
    wq = '{32'h1122_3344};
    do_load(1'b0, 1'b0);
    do_reset();
    do_load(1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader placed between the `mips` core and `exmemory`, on the core's memory port. After reset it holds the core in reset and accepts a length-prefixed stream of 32-bit words over a valid/ready byte interface. It writes each word into consecutive memory locations, then releases the core and becomes a transparent pass-through of the core's memory writes. This lets the board load a program without a memory initialisation file.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000, byte address of the first loaded word.
- `MAX_WORDS`, 16384, largest accepted word count; must satisfy BASE_ADDR + 4*MAX_WORDS ≤ 2^16.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  rx_data valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `cpu_mem_write`  in  1  core MemWrite.
- `cpu_mem_addr`  in  16  core byte address.
- `cpu_mem_wdata`  in  32  core write data.
- `mem_write`  out  1  to exmemory MemWrite.
- `mem_addr`  out  16  to exmemory address; core reads also use it.
- `mem_wdata`  out  32  to exmemory write data.
- `cpu_hold`  out  1  active-high reset to the core.
- `done`  out  1  load complete; core running.
- `error`  out  1  load aborted.

## Operation
- A byte is transferred on a rising edge when rx_valid && rx_ready. rx_valid may drop or stall at any time. A byte not accepted is not consumed.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first. With CHECKSUM_EN, one trailing checksum byte follows.
- States:
  - HDR_HI → HDR_LO → (N==0 ? end : DATA).
  - DATA collects 4 bytes. On the 4th byte it goes to WRITE.
  - WRITE lasts one cycle. Then it goes to DATA if words remain, otherwise to end.
  - end is CSUM when CHECKSUM_EN is defined, otherwise RUN.
  - N > MAX_WORDS detected in HDR_LO → ERROR.
  - RUN and ERROR are terminal until reset.
- rx_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in WRITE, RUN and ERROR.
- Write address: the load address starts at BASE_ADDR, increments by 4 after each WRITE, and wraps modulo 2^16. The parameter constraint prevents wrapping in legal configurations.
- In WRITE: mem_write = 1, mem_addr = the load address, mem_wdata = the assembled word.
- In any other non-RUN state: mem_write = 0, mem_addr = the load address, mem_wdata = the assembled word.
- In RUN, mem_write, mem_addr and mem_wdata equal cpu_mem_write, cpu_mem_addr and cpu_mem_wdata combinationally.
- cpu_hold = 1 in every state except RUN. done = (state == RUN). error = (state == ERROR).
- Reset asserted in any state, including mid-word or mid-WRITE:
  - returns to HDR_HI;
  - clears the word count, byte index, load address and assembled word;
  - drops mem_write immediately (asynchronously).
  - Memory contents already written are not cleared.

## Timing
- Reset values: state HDR_HI, rx_ready 1, mem_write 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_hold 1, done 0, error 0.
- 4th byte of a word accepted at edge k:
  - mem_write is high for exactly one cycle, from edge k to edge k+1.
  - The write commits to exmemory at edge k+1.
  - rx_ready returns high after edge k+1.
- Peak throughput is one word per 5 cycles.
- Last write committed (or checksum accepted) at edge m: cpu_hold falls and done rises after edge m. The core leaves reset at edge m+1.
- ERROR is entered on the edge that accepts count_lo, or that accepts a bad checksum.

## Configuration
- Macro `BOOT_LOADER_CHECKSUM_EN`.
- When defined:
  - A running XOR of all payload bytes is kept; it resets to 0 in HDR_HI and excludes the header bytes.
  - CSUM accepts one byte. A match goes to RUN; a mismatch goes to ERROR.
  - Words are still written before the check, so ERROR leaves them in memory with the core held.
- When undefined: there is no CSUM state and no XOR register; the last WRITE goes to RUN.

## Structure
- Package `boot_loader_pkg` holds:
  - the state enum: HDR_HI, HDR_LO, DATA, WRITE, CSUM, RUN, ERROR;
  - the address width (16);
  - the word width (32);
  - the header length (2).
- One sub-module, `boot_word_packer`:
  - 4-byte MSB-first shift register with a 2-bit byte index;
  - inputs: shift enable, clear;
  - outputs: word, a `full` pulse on the 4th byte.
- The top level holds the FSM, the word counter, the address counter, the checksum and the output mux.

## Test plan
- Stream 00 02 20 08 00 05 AC 08 00 00, rx_valid held high → writes 0x20080005 @0x0000 and 0xAC080000 @0x0004, each mem_write pulse one cycle; cpu_hold falls one cycle after the second write; afterwards mem_* follow cpu_mem_*.
- Stream 00 00 → no mem_write; done = 1 one cycle after count_lo is accepted.
- Count 0x4001 with default MAX_WORDS → error = 1, rx_ready = 0, cpu_hold stays 1; the following bytes are ignored.
- Random rx_valid gaps (50% duty) on a 3-word load → identical memory image; no byte is lost or duplicated while rx_ready = 0 in WRITE.
- Reset pulse after the 2nd byte of word 1 → mem_write drops at once; a reload of 00 01 DE AD BE EF writes 0xDEADBEEF @BASE_ADDR.
- With BOOT_LOADER_CHECKSUM_EN, stream 00 01 11 22 33 44 then checksum 0x44 → RUN; the same stream with checksum 0x45 → ERROR.
